// File: rtl/rev_serial_adder.sv
// Multi-cycle reversible adder/subtractor: B <- A+B+cin (FWD) or B <- B-A-cin (REV),
// BPC bits per clock through chained reversible full-adder cells.

module rev_fa_cell (
  input  logic mode_i,
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  logic bd;
  // REV is an add on ~b with the sum re-inverted: d = b^a^c, borrow = maj(a,~b,c)
  assign bd  = b_i ^ mode_i;
  assign c_o = (a_i & bd) | (a_i & c_i) | (bd & c_i);
  assign s_o = a_i ^ bd ^ c_i ^ mode_i;
endmodule

module rev_serial_adder #(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             carry_out
);
  localparam int NCH = WIDTH / BPC;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, b_d, a_out_q, b_out_q;
  logic             mode_q, c_q, c_d, busy_q, done_q, cout_q;
  logic [IW-1:0]    idx_q;
  logic [BPC-1:0]   a_ch, b_ch, r_ch;
  logic [BPC:0]     cc;

  assign a_ch  = a_q[idx_q*BPC +: BPC];
  assign b_ch  = b_q[idx_q*BPC +: BPC];
  assign cc[0] = c_q;

  for (genvar i = 0; i < BPC; i++) begin : g_cell
    rev_fa_cell u_cell (
      .mode_i (mode_q),
      .a_i    (a_ch[i]),
      .b_i    (b_ch[i]),
      .c_i    (cc[i]),
      .s_o    (r_ch[i]),
      .c_o    (cc[i+1])
    );
  end

  always_comb begin
    b_d = b_q;
    b_d[idx_q*BPC +: BPC] = r_ch;
    c_d = cc[BPC];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      c_q     <= 1'b0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      a_out_q <= '0;
      b_out_q <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          a_q     <= a_in;
          b_q     <= b_in;
          mode_q  <= mode;
          c_q     <= cin;
          idx_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= RUN;
        end
        RUN: begin
          b_q   <= b_d;
          c_q   <= c_d;
          idx_q <= idx_q + 1'b1;
          // outputs are only published on the DONE entry edge
          if (int'(idx_q) == NCH - 1) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            a_out_q <= a_q;
            b_out_q <= b_d;
            cout_q  <= c_d;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign a_out     = a_out_q;
  assign b_out     = b_out_q;
  assign carry_out = cout_q;
endmodule

// File: tb/tb_rev_serial_adder.sv
// Scoreboard bench: four W=8 instances (BPC 1/2/4/8) plus one W=1 instance.
module tb_rev_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       st [5], md [5], cw [5];
  logic [7:0] ai [5], bi [5];
  logic       by [5], dn [5], co [5];
  logic [7:0] ao [5], bo [5];
  logic       w1_ao, w1_bo;

  localparam int BPCS [5] = '{1, 2, 4, 8, 1};

  for (genvar g = 0; g < 4; g++) begin : g_dut
    rev_serial_adder #(.WIDTH(8), .BPC(BPCS[g])) u_dut (
      .clk(clk), .rst_n(rst_n), .start(st[g]), .mode(md[g]),
      .a_in(ai[g]), .b_in(bi[g]), .cin(cw[g]),
      .busy(by[g]), .done(dn[g]), .a_out(ao[g]), .b_out(bo[g]), .carry_out(co[g])
    );
  end

  rev_serial_adder #(.WIDTH(1), .BPC(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .start(st[4]), .mode(md[4]),
    .a_in(ai[4][0]), .b_in(bi[4][0]), .cin(cw[4]),
    .busy(by[4]), .done(dn[4]), .a_out(w1_ao), .b_out(w1_bo), .carry_out(co[4])
  );
  assign ao[4] = {7'd0, w1_ao};
  assign bo[4] = {7'd0, w1_bo};

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    int         lat;
  } exp_t;

  exp_t sb [5][$];
  int nvec = 0;
  int nfail = 0;

  task automatic push_exp(input int k, input logic m, input logic [7:0] a, b, input logic ci);
    int w, mask, full;
    exp_t e;
    w    = (k == 4) ? 1 : 8;
    mask = (1 << w) - 1;
    e.a  = a;
    e.lat = w / BPCS[k] + 1;
    if (!m) begin
      full = int'(a) + int'(b) + int'(ci);
      e.b  = 8'((full & mask));
      e.c  = ((full >> w) & 1) != 0;
    end else begin
      full = int'(b) - int'(a) - int'(ci);
      e.b  = 8'((full & mask));
      e.c  = (int'(a) + int'(ci)) > int'(b);
    end
    sb[k].push_back(e);
  endtask

  // waits for done (bounded), pops the scoreboard and compares
  task automatic wait_check(input int k, input string nm, output logic [7:0] rb, output logic rc);
    int lat;
    exp_t e;
    lat = 1;
    while (dn[k] !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    e = sb[k].pop_front();
    rb = bo[k];
    rc = co[k];
    nvec++;
    if (lat !== e.lat) begin
      nfail++;
      $display("FAIL %s[%0d] latency: got %0d want %0d", nm, k, lat, e.lat);
    end
    nvec++;
    if (bo[k] !== e.b || co[k] !== e.c || ao[k] !== e.a) begin
      nfail++;
      $display("FAIL %s[%0d] result: got a=%h b=%h c=%b want a=%h b=%h c=%b",
               nm, k, ao[k], bo[k], co[k], e.a, e.b, e.c);
    end
  endtask

  task automatic op(input int k, input logic m, input logic [7:0] a, b, input logic ci,
                    output logic [7:0] rb, output logic rc);
    push_exp(k, m, a, b, ci);
    @(negedge clk);
    md[k] = m; ai[k] = a; bi[k] = b; cw[k] = ci; st[k] = 1'b1;
    @(posedge clk); #1;
    st[k] = 1'b0;
    ai[k] = 8'($urandom); bi[k] = 8'($urandom); cw[k] = 1'($urandom);
    wait_check(k, "op", rb, rc);
    @(posedge clk); #1;
    nvec++;
    if (dn[k] !== 1'b0 || by[k] !== 1'b0) begin
      nfail++;
      $display("FAIL pulse[%0d]: got done=%b busy=%b want 0 0", k, dn[k], by[k]);
    end
  endtask

  task automatic test_reset;
    for (int k = 0; k < 5; k++) begin
      nvec++;
      if (by[k] !== 1'b0 || dn[k] !== 1'b0 || ao[k] !== 8'd0 || bo[k] !== 8'd0 || co[k] !== 1'b0) begin
        nfail++;
        $display("FAIL reset[%0d]: got busy=%b done=%b a=%h b=%h c=%b want all 0",
                 k, by[k], dn[k], ao[k], bo[k], co[k]);
      end
    end
  endtask

  task automatic test_directed;
    logic [7:0] rb;
    logic rc;
    op(0, 1'b0, 8'h5A, 8'h3C, 1'b0, rb, rc);
    op(0, 1'b0, 8'hFF, 8'h01, 1'b1, rb, rc);
    op(0, 1'b1, 8'hFF, 8'h01, 1'b1, rb, rc);
    op(0, 1'b1, 8'h01, 8'h00, 1'b0, rb, rc);
    op(0, 1'b1, 8'h5A, 8'h96, 1'b0, rb, rc);
    op(3, 1'b0, 8'hFF, 8'h01, 1'b1, rb, rc);
  endtask

  task automatic round_trip(input int k, input int n);
    logic [7:0] a, b, r1, r2;
    logic c, c1, c2;
    for (int i = 0; i < n; i++) begin
      a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
      op(k, 1'b0, a, b, c, r1, c1);
      op(k, 1'b1, a, r1, c, r2, c2);
      nvec++;
      if (r2 !== b || c2 !== c1) begin
        nfail++;
        $display("FAIL roundtrip[%0d]: got b=%h c=%b want b=%h c=%b", k, r2, c2, b, c1);
      end
    end
  endtask

  task automatic test_round_trip;
    fork
      round_trip(0, 1000);
      round_trip(1, 1000);
      round_trip(2, 1000);
      round_trip(3, 1000);
    join
  endtask

  task automatic test_start_held;
    logic [7:0] rb;
    logic rc;
    push_exp(0, 1'b0, 8'h5A, 8'h3C, 1'b0);
    @(negedge clk);
    md[0] = 1'b0; ai[0] = 8'h5A; bi[0] = 8'h3C; cw[0] = 1'b0; st[0] = 1'b1;
    @(posedge clk); #1;
    ai[0] = 8'hFF; bi[0] = 8'h00;
    wait_check(0, "held1", rb, rc);
    @(posedge clk); #1;
    nvec++;
    if (dn[0] !== 1'b0 || by[0] !== 1'b0) begin
      nfail++;
      $display("FAIL held_idle: got done=%b busy=%b want 0 0", dn[0], by[0]);
    end
    push_exp(0, 1'b0, 8'hFF, 8'h00, 1'b0);
    @(posedge clk); #1;
    nvec++;
    if (by[0] !== 1'b1) begin
      nfail++;
      $display("FAIL held_restart: got busy=%b want 1", by[0]);
    end
    st[0] = 1'b0;
    wait_check(0, "held2", rb, rc);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midrun;
    logic [7:0] rb;
    logic rc;
    @(negedge clk);
    md[0] = 1'b0; ai[0] = 8'h12; bi[0] = 8'h34; cw[0] = 1'b1; st[0] = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    nvec++;
    if (by[0] !== 1'b0 || dn[0] !== 1'b0 || ao[0] !== 8'd0 || bo[0] !== 8'd0 || co[0] !== 1'b0) begin
      nfail++;
      $display("FAIL midrun_reset: got busy=%b done=%b a=%h b=%h c=%b want all 0",
               by[0], dn[0], ao[0], bo[0], co[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    op(0, 1'b0, 8'h5A, 8'h3C, 1'b0, rb, rc);
  endtask

  task automatic test_width1;
    logic [7:0] rb;
    logic rc;
    for (int v = 0; v < 16; v++)
      op(4, v[3], {7'd0, v[2]}, {7'd0, v[1]}, v[0], rb, rc);
  endtask

  initial begin
    for (int k = 0; k < 5; k++) begin
      st[k] = 1'b0; md[k] = 1'b0; cw[k] = 1'b0; ai[k] = '0; bi[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    @(negedge clk);
    rst_n = 1'b1;
    test_directed;
    test_start_held;
    test_reset_midrun;
    test_width1;
    test_round_trip;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
